// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: byte width, default baud divider
// and the sequencing FSM state encoding.
package uart_tx_arbiter_pkg;

    localparam int UART_BYTE_W = 8;
    localparam int DEF_BPS_NUM = 434;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT_HI = 2'd2,
        ST_WAIT_LO = 2'd3
    } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Packet-source and uart_tx side signals of the arbiter; master drives the sources and
// tx_busy, slave is the arbiter itself.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 3
);

    logic [NUM_REQ-1:0]                                  req_valid;
    logic [uart_tx_arbiter_pkg::UART_BYTE_W*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]                                  req_last;
    logic [NUM_REQ-1:0]                                  req_ready;
    logic                                                tx_busy;
    logic [uart_tx_arbiter_pkg::UART_BYTE_W-1:0]         tx_data;
    logic                                                tx_pluse;
    logic [NUM_REQ-1:0]                                  grant;
    logic                                                err_stall;

    modport master (
        output req_valid, req_data, req_last, tx_busy,
        input  req_ready, tx_data, tx_pluse, grant, err_stall
    );

    modport slave (
        input  req_valid, req_data, req_last, tx_busy,
        output req_ready, tx_data, tx_pluse, grant, err_stall
    );

endinterface

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Combinational round-robin picker: one-hot grant to the first requester strictly
// after ptr, wrapping modulo N.
module rr_arbiter #(
    parameter int  N  = 3,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);

    logic          found;
    logic [PW-1:0] idx;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= N; k++) begin
            idx = PW'((int'(ptr) + k) % N);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin owner of the shared UART transmitter: grants one packet source at a time
// and hands its bytes to uart_tx as single-cycle strobes paced on tx_busy.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ       = 3,
    parameter int BUSY_RISE_MAX = 8,
    parameter int STALL_MAX     = 4096
) (
    input logic              clk,
    input logic              reset,
    uart_tx_arbiter_if.slave bus
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int SW = $clog2(STALL_MAX + 1);
    localparam int RW = $clog2(BUSY_RISE_MAX + 1);
    localparam logic [PW-1:0] PTR_RST   = PW'(NUM_REQ - 1);
    localparam logic [SW-1:0] STALL_LIM = SW'(STALL_MAX - 1);
    localparam logic [RW-1:0] RISE_LIM  = RW'(BUSY_RISE_MAX - 1);

    arb_state_e             state_q, state_d;
    logic [NUM_REQ-1:0]     grant_q, grant_d;
    logic [NUM_REQ-1:0]     rr_gnt;
    logic [NUM_REQ-1:0]     req_ready_c;
    logic [PW-1:0]          ptr_q, ptr_d;
    logic [PW-1:0]          gidx;
    logic [UART_BYTE_W-1:0] tx_data_q, tx_data_d;
    logic [UART_BYTE_W-1:0] g_byte;
    logic                   g_valid, g_last;
    logic                   tx_pluse_q, tx_pluse_d;
    logic                   last_q, last_d;
    logic                   err_stall_q, err_stall_d;
    logic [SW-1:0]          stall_cnt_q, stall_cnt_d;
    logic [RW-1:0]          rise_cnt_q, rise_cnt_d;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req (bus.req_valid),
        .ptr (ptr_q),
        .gnt (rr_gnt)
    );

    // Steer the granted source's lane onto scalar signals.
    always_comb begin
        gidx    = '0;
        g_byte  = '0;
        g_valid = 1'b0;
        g_last  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) begin
                gidx    = PW'(i);
                g_byte  = bus.req_data[UART_BYTE_W*i +: UART_BYTE_W];
                g_valid = bus.req_valid[i];
                g_last  = bus.req_last[i];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        ptr_d       = ptr_q;
        tx_data_d   = tx_data_q;
        tx_pluse_d  = 1'b0;
        last_d      = last_q;
        err_stall_d = 1'b0;
        stall_cnt_d = stall_cnt_q;
        rise_cnt_d  = rise_cnt_q;
        req_ready_c = '0;

        case (state_q)
            ST_IDLE: begin
                if (|bus.req_valid) begin
                    grant_d = rr_gnt;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                req_ready_c = grant_q & bus.req_valid & {NUM_REQ{~bus.tx_busy}};
                if (g_valid && !bus.tx_busy) begin
                    tx_data_d  = g_byte;
                    tx_pluse_d = 1'b1;
                    last_d     = g_last;
                    state_d    = ST_WAIT_HI;
                end else if (!g_valid) begin
                    if (stall_cnt_q == STALL_LIM) begin
                        err_stall_d = 1'b1;
                        grant_d     = '0;
                        ptr_d       = gidx;
                        state_d     = ST_IDLE;
                    end else begin
                        stall_cnt_d = stall_cnt_q + 1'b1;
                    end
                end else begin
                    stall_cnt_d = '0;
                end
            end
            ST_WAIT_HI: begin
                // A uart_tx that never raises busy must not wedge the arbiter.
                if (bus.tx_busy || rise_cnt_q == RISE_LIM) begin
                    state_d = ST_WAIT_LO;
                end else begin
                    rise_cnt_d = rise_cnt_q + 1'b1;
                end
            end
            ST_WAIT_LO: begin
                if (!bus.tx_busy) begin
                    if (last_q) begin
                        ptr_d   = gidx;
                        grant_d = '0;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d != state_q) begin
            stall_cnt_d = '0;
            rise_cnt_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            ptr_q       <= PTR_RST;
            tx_data_q   <= '0;
            tx_pluse_q  <= 1'b0;
            last_q      <= 1'b0;
            err_stall_q <= 1'b0;
            stall_cnt_q <= '0;
            rise_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            ptr_q       <= ptr_d;
            tx_data_q   <= tx_data_d;
            tx_pluse_q  <= tx_pluse_d;
            last_q      <= last_d;
            err_stall_q <= err_stall_d;
            stall_cnt_q <= stall_cnt_d;
            rise_cnt_q  <= rise_cnt_d;
        end
    end

    assign bus.req_ready = req_ready_c;
    assign bus.tx_data   = tx_data_q;
    assign bus.tx_pluse  = tx_pluse_q;
    assign bus.grant     = grant_q;
    assign bus.err_stall = err_stall_q;

endmodule
